// File: rtl/chunked_adder_sub_if.sv
// -----------------------------------------------------------------------------
// chunked_adder_sub_if
// Handshake and data bundle between a controlling FSM and chunked_adder_sub.
//   start  : request, sampled by the adder only when it is idle or done
//   sub    : 0 = a+b, 1 = a-b (sampled with start)
//   a, b   : WIDTH-bit operands (sampled with start)
//   busy   : operation in progress
//   done   : single-cycle completion pulse
//   sum    : registered result, held until the next completion
//   cout   : carry out of the MSB (subtract: 1 = no borrow)
//   ovf    : two's-complement signed overflow
// The master modport belongs to the controller; the slave modport to the adder.
// -----------------------------------------------------------------------------
interface chunked_adder_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/chunked_adder_sub.sv
// -----------------------------------------------------------------------------
// chunked_adder_sub
// Multi-cycle adder/subtractor. A WIDTH-bit operand pair is processed CHUNK
// bits per clock through a CHUNK-bit ripple stage with a registered carry, so
// an operation takes NCHUNK = WIDTH/CHUNK clocks.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : chunked_adder_sub_if.slave (start/sub/a/b in, busy/done/sum/cout/ovf out)
//
// Optional build macro ADDER_SATURATE_EN: when defined, a signed-overflowing
// result is clamped to the most positive / most negative value (direction
// taken from A's sign). cout and ovf always report the unsaturated result.
// -----------------------------------------------------------------------------
module chunked_adder_sub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic                clk,
  input  logic                rst,
  chunked_adder_sub_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;       // operand B, already inverted for subtract
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic [CHUNK:0]     chunk_sum;
  logic [WIDTH-1:0]   res_next;
  logic               ovf_calc;

`ifdef ADDER_SATURATE_EN
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] wrapped,
                                                input logic             a_msb,
                                                input logic             ovf);
    if (!ovf) return wrapped;
    return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  always_comb begin
    // Select the active chunk of each operand.
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end

    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

    // Result register with the freshly computed chunk merged in; on the last
    // chunk this is the complete result, used directly for the outputs.
    res_next = res_q;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDX_W'(i)) res_next[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    ovf_calc = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_next[WIDTH-1] != a_q[WIDTH-1]);

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          // Subtract as A + ~B + 1: invert B here, seed the carry with sub.
          state_d = RUN;
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{bus.sub}};
          carry_d = bus.sub;
          idx_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_d   = res_next;
        carry_d = chunk_sum[CHUNK];
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NCHUNK-1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cout_d  = chunk_sum[CHUNK];
          ovf_d   = ovf_calc;
`ifdef ADDER_SATURATE_EN
          sum_d   = saturate(res_next, a_q[WIDTH-1], ovf_calc);
`else
          sum_d   = res_next;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_adder_sub.sv
// -----------------------------------------------------------------------------
// tb_chunked_adder_sub
// Scoreboard bench for chunked_adder_sub with two instances: WIDTH=8/CHUNK=1
// and WIDTH=16/CHUNK=4. Accepted operations push their expected result; a
// monitor pops and compares whenever done is presented.
// -----------------------------------------------------------------------------
module tb_chunked_adder_sub;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  exp_t q8[$];
  exp_t q16[$];

  always #5 clk = ~clk;

  chunked_adder_sub_if #(.WIDTH(8))  bus8 ();
  chunked_adder_sub_if #(.WIDTH(16)) bus16 ();

  chunked_adder_sub #(.WIDTH(8), .CHUNK(1)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  chunked_adder_sub #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void push8(input logic [7:0] s, input logic c, input logic o);
    exp_t e;
    e.sum = {8'h00, s}; e.cout = c; e.ovf = o;
    q8.push_back(e);
  endfunction

  function automatic void push16(input logic [15:0] s, input logic c, input logic o);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o;
    q16.push_back(e);
  endfunction

  // Monitors: compare every presented result with the scoreboard head.
  always @(negedge clk) begin
    if (bus8.done === 1'b1) begin
      if (q8.size() == 0) begin
        tests++; fails++;
        $display("FAIL done8_unexpected: got done=1 sum=0x%0h expected no completion", bus8.sum);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("sum8",  {24'h0, bus8.sum}, {16'h0, e.sum});
        check("cout8", {31'h0, bus8.cout}, {31'h0, e.cout});
        check("ovf8",  {31'h0, bus8.ovf},  {31'h0, e.ovf});
      end
    end
  end

  always @(negedge clk) begin
    if (bus16.done === 1'b1) begin
      if (q16.size() == 0) begin
        tests++; fails++;
        $display("FAIL done16_unexpected: got done=1 sum=0x%0h expected no completion", bus16.sum);
      end else begin
        exp_t e;
        e = q16.pop_front();
        check("sum16",  {16'h0, bus16.sum}, {16'h0, e.sum});
        check("cout16", {31'h0, bus16.cout}, {31'h0, e.cout});
        check("ovf16",  {31'h0, bus16.ovf},  {31'h0, e.ovf});
      end
    end
  end

  task automatic do_start8(input logic [7:0] a, input logic [7:0] b, input logic sub);
    bus8.a = a; bus8.b = b; bus8.sub = sub; bus8.start = 1'b1;
    @(posedge clk);
    #1 bus8.start = 1'b0;
  endtask

  task automatic do_start16(input logic [15:0] a, input logic [15:0] b, input logic sub);
    bus16.a = a; bus16.b = b; bus16.sub = sub; bus16.start = 1'b1;
    @(posedge clk);
    #1 bus16.start = 1'b0;
  endtask

  // Counts edges until done appears (measured from the last start edge) and
  // busy cycles seen on the way. exp_busy < 0 skips the busy count.
  task automatic wait_done(input int sel, input int exp_edges, input int exp_busy, input string name);
    int edges = 0;
    int busyc = 0;
    bit seen  = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if ((sel == 8) ? bus8.busy : bus16.busy) busyc++;
      if ((sel == 8) ? bus8.done : bus16.done) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      edges++;
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got no done within 100 cycles expected done after %0d edges", name, exp_edges);
    end else begin
      check({name, "_latency"}, edges, exp_edges);
      if (exp_busy >= 0) check({name, "_busy_cycles"}, busyc, exp_busy);
    end
  endtask

  initial begin
    int dcount;
    bus8.start = 0; bus8.sub = 0; bus8.a = '0; bus8.b = '0;
    bus16.start = 0; bus16.sub = 0; bus16.a = '0; bus16.b = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy8", {31'h0, bus8.busy}, 0);
    check("rst_done8", {31'h0, bus8.done}, 0);
    check("rst_sum8",  {24'h0, bus8.sum}, 0);
    check("rst_cout8", {31'h0, bus8.cout}, 0);
    check("rst_ovf8",  {31'h0, bus8.ovf}, 0);
    check("rst_busy16", {31'h0, bus16.busy}, 0);
    check("rst_sum16",  {16'h0, bus16.sum}, 0);

    // 0x35 + 0x4A
    push8(8'h7F, 1'b0, 1'b0);
    do_start8(8'h35, 8'h4A, 1'b0);
    wait_done(8, 8, 8, "add_35_4a");
    repeat (2) @(negedge clk);

    // 0xFF + 0x01 wraps with carry
    push8(8'h00, 1'b1, 1'b0);
    do_start8(8'hFF, 8'h01, 1'b0);
    wait_done(8, 8, 8, "add_ff_01");
    repeat (2) @(negedge clk);

    // 0x10 - 0x20 borrows
    push8(8'hF0, 1'b0, 1'b0);
    do_start8(8'h10, 8'h20, 1'b1);
    wait_done(8, 8, 8, "sub_10_20");
    repeat (2) @(negedge clk);

    // 0x80 - 0x01 overflows
`ifdef ADDER_SATURATE_EN
    push8(8'h80, 1'b1, 1'b1);
`else
    push8(8'h7F, 1'b1, 1'b1);
`endif
    do_start8(8'h80, 8'h01, 1'b1);
    wait_done(8, 8, 8, "sub_80_01");
    repeat (2) @(negedge clk);

    // start during busy cycle 3 is ignored
    push8(8'h03, 1'b0, 1'b0);
    do_start8(8'h01, 8'h02, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 bus8.a = 8'hAA; bus8.b = 8'h55; bus8.start = 1'b1;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    wait_done(8, 5, -1, "ignore_start");
    // back-to-back start in the done cycle
    push8(8'h0B, 1'b0, 1'b0);
    do_start8(8'h05, 8'h06, 1'b0);
    wait_done(8, 8, 8, "back_to_back");
    repeat (2) @(negedge clk);

    // reset during busy cycle 4 aborts the op
    do_start8(8'h12, 8'h34, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'h0, bus8.busy}, 0);
    check("abort_done", {31'h0, bus8.done}, 0);
    check("abort_sum",  {24'h0, bus8.sum}, 0);
    check("abort_cout", {31'h0, bus8.cout}, 0);
    check("abort_ovf",  {31'h0, bus8.ovf}, 0);
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done) dcount++;
    end
    check("abort_no_done", dcount, 0);
    push8(8'h02, 1'b0, 1'b0);
    do_start8(8'h01, 8'h01, 1'b0);
    wait_done(8, 8, 8, "after_abort");
    repeat (2) @(negedge clk);

    // rst and start together: rst wins
    bus8.a = 8'h03; bus8.b = 8'h03; bus8.sub = 1'b0; bus8.start = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; bus8.start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", {31'h0, bus8.busy}, 0);
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done) dcount++;
    end
    check("rst_start_no_done", dcount, 0);

    // 16-bit, 4-bit chunks: 0x7FFF + 1 overflows
`ifdef ADDER_SATURATE_EN
    push16(16'h7FFF, 1'b0, 1'b1);
`else
    push16(16'h8000, 1'b0, 1'b1);
`endif
    do_start16(16'h7FFF, 16'h0001, 1'b0);
    wait_done(16, 4, 4, "w16_add");
    repeat (2) @(negedge clk);

    check("sb8_drained",  q8.size(), 0);
    check("sb16_drained", q16.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
